axi_pattern_checker: RTL and testbench

- Read-back verifier that sits downstream of the AXI pattern writer on the same memory target.
- On trigger it issues one INCR read burst at ADDR through an axi_ifc.master port.
- It compares every returned beat with the writer's rotating pattern and reports pass/fail, the mismatch count and protocol errors.
- It closes the write/read-back loop for board bring-up of the HP/GP ports.

---
 rtl/axi_pattern_pkg.sv | 20 ++
 rtl/axi_ifc.sv | 71 +++++++
 rtl/axi_pattern_checker_pattern_gen.sv | 23 ++
 rtl/axi_pattern_checker.sv | 176 +++++++++++++++++
 tb/tb_axi_pattern_checker.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pattern_pkg.sv
// Definitions shared by the AXI pattern writer and checker: the rotating data
// pattern, the AXI encodings both sides drive, and the checker state type.
package axi_pattern_pkg;

    localparam logic [31:0] PTTN_DEFAULT = 32'h1234_5678;
    localparam logic [1:0]  BURST_INCR   = 2'd1;
    localparam logic [2:0]  SIZE_4B      = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        RADDR,
        RDATA,
        REPORT
    } chk_state_t;

    function automatic logic [31:0] pattern_next(input logic [31:0] w);
        return {w[3:0], w[31:4]};
    endfunction

endpackage

// File: rtl/axi_ifc.sv
// AXI3 bundle with 32-bit address/data and 4-bit IDs.
interface axi_ifc;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_pattern_checker_pattern_gen.sv
// Rotating pattern source; the writer and checker both use it so they walk
// through the same word sequence.
module pattern_gen
    import axi_pattern_pkg::*;
#(
    parameter logic [31:0] PTTN = PTTN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            value <= PTTN;
        end else if (advance) begin
            value <= pattern_next(value);
        end
    end

endmodule

// File: rtl/axi_pattern_checker.sv
// Read-back verifier: issues one INCR read burst and checks every beat against
// the writer's rotating pattern, reporting pass, mismatch count and rlast errors.
//
//   state  | meaning
//   IDLE   | waiting for trigger
//   RADDR  | AR request outstanding
//   RDATA  | accepting and checking read beats
//   REPORT | one-cycle done pulse, results published
module axi_pattern_checker
    import axi_pattern_pkg::*;
#(
    parameter logic [31:0] ADDR  = 32'h0000_0000,
    parameter logic [31:0] PTTN  = PTTN_DEFAULT,
    parameter int          BEATS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    axi_ifc.master      m,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic        proto_err,
    output logic [31:0] first_bad
);

    localparam logic [3:0] BEAT_LAST = 4'(BEATS - 1);
    localparam logic [4:0] ERR_MAX   = 5'd16;

    chk_state_t  state, state_nx;
    logic        arvalid_q, arvalid_nx;
    logic        rready_q, rready_nx;
    logic        busy_nx, done_nx, pass_nx, proto_nx;
    logic [4:0]  err_nx;
    logic [31:0] first_nx;
    logic [3:0]  beat, beat_nx;
    logic        load, advance;
    logic        beat_fire, beat_bad;
    logic [31:0] expected;

    pattern_gen #(.PTTN(PTTN)) u_expected (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .value   (expected)
    );

    assign m.arid    = 4'd0;
    assign m.araddr  = ADDR;
    assign m.arlen   = BEAT_LAST;
    assign m.arsize  = SIZE_4B;
    assign m.arburst = BURST_INCR;
    assign m.arlock  = 2'd0;
    assign m.arcache = 4'd0;
    assign m.arprot  = 3'd0;
    assign m.arvalid = arvalid_q;
    assign m.rready  = rready_q;

    // Write channels are parked; this block only reads.
    assign m.awid    = 4'd0;
    assign m.awaddr  = 32'd0;
    assign m.awlen   = 4'd0;
    assign m.awsize  = 3'd0;
    assign m.awburst = 2'd0;
    assign m.awlock  = 2'd0;
    assign m.awcache = 4'd0;
    assign m.awprot  = 3'd0;
    assign m.awvalid = 1'b0;
    assign m.wid     = 4'd0;
    assign m.wdata   = 32'd0;
    assign m.wstrb   = 4'd0;
    assign m.wlast   = 1'b0;
    assign m.wvalid  = 1'b0;
    assign m.bready  = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{m.awready, m.wready, m.bid, m.bresp, m.bvalid, m.rid};

    assign beat_fire = m.rvalid && rready_q;
    assign beat_bad  = (m.rdata != expected) || (m.rresp != 2'b00);

    always_comb begin
        state_nx   = state;
        arvalid_nx = arvalid_q;
        rready_nx  = rready_q;
        busy_nx    = busy;
        done_nx    = 1'b0;
        pass_nx    = pass;
        err_nx     = err_count;
        proto_nx   = proto_err;
        first_nx   = first_bad;
        beat_nx    = beat;
        load       = 1'b0;
        advance    = 1'b0;

        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx = RADDR;
                    busy_nx  = 1'b1;
                    err_nx   = 5'd0;
                    proto_nx = 1'b0;
                    pass_nx  = 1'b0;
                    first_nx = 32'd0;
                end
            end
            RADDR: begin
                if (arvalid_q && m.arready) begin
                    state_nx   = RDATA;
                    arvalid_nx = 1'b0;
                    rready_nx  = 1'b1;
                end else begin
                    arvalid_nx = 1'b1;
                end
            end
            RDATA: begin
                if (beat_fire) begin
                    advance = 1'b1;
                    if (beat_bad) begin
                        if (err_count < ERR_MAX) err_nx = err_count + 5'd1;
                        if (err_count == 5'd0)   first_nx = m.rdata;
                    end
                    // Overlong bursts park on the last index so the rlast check stays meaningful.
                    if (beat != BEAT_LAST) beat_nx = beat + 4'd1;
                    if (m.rlast) begin
                        if (beat != BEAT_LAST) proto_nx = 1'b1;
                        rready_nx = 1'b0;
                        state_nx  = REPORT;
                        done_nx   = 1'b1;
                        busy_nx   = 1'b0;
                        pass_nx   = (err_nx == 5'd0) && !proto_nx;
                    end else if (beat == BEAT_LAST) begin
                        proto_nx = 1'b1;
                    end
                end
            end
            REPORT: begin
                state_nx = IDLE;
                load     = 1'b1;
                beat_nx  = 4'd0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 5'd0;
            proto_err <= 1'b0;
            first_bad <= 32'd0;
            beat      <= 4'd0;
        end else begin
            state     <= state_nx;
            arvalid_q <= arvalid_nx;
            rready_q  <= rready_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            err_count <= err_nx;
            proto_err <= proto_nx;
            first_bad <= first_nx;
            beat      <= beat_nx;
        end
    end

endmodule

// File: tb/tb_axi_pattern_checker.sv
// Directed bench for axi_pattern_checker: a behavioural AXI read slave plus a
// table of burst scenarios and hand-written trigger/reset sequences.
module tb_axi_pattern_checker;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic        busy, done, pass, proto_err;
    logic [4:0]  err_count;
    logic [31:0] first_bad;

    axi_ifc m_if ();

    axi_pattern_checker dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .m         (m_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .proto_err (proto_err),
        .first_bad (first_bad)
    );

    typedef struct {
        int          ar_delay;
        bit          rnd;
        int          bad_data;
        int          bad_resp;
        bit          all_bad;
        int          last;
        int          exp_cyc;
        bit          exp_pass;
        int          exp_err;
        bit          exp_proto;
        logic [31:0] exp_fb;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] pat_tab [8];

    int n_checks = 0;
    int n_pass   = 0;

    int cfg_ar_delay = 0;
    bit cfg_rnd      = 0;
    int cfg_bad_data = -1;
    int cfg_bad_resp = -1;
    bit cfg_all_bad  = 0;
    int cfg_last     = 15;

    int ar_count   = 0;
    int beats_seen = 0;
    int ar_drops   = 0;
    int done_total = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_ar_delay = v.ar_delay;
        cfg_rnd      = v.rnd;
        cfg_bad_data = v.bad_data;
        cfg_bad_resp = v.bad_resp;
        cfg_all_bad  = v.all_bad;
        cfg_last     = v.last;
    endtask

    // Read slave: decisions use values sampled at the negedge, which equal the
    // values seen by the DUT at the following posedge.
    initial begin : slave
        int idx, ar_wait;
        bit active, arf, rf, av, rst;
        idx = 0; ar_wait = 0; active = 0;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bid = 4'd0; m_if.bresp = 2'd0; m_if.bvalid = 1'b0;
        m_if.arready = 1'b0; m_if.rid = 4'd0; m_if.rdata = 32'd0;
        m_if.rresp = 2'd0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
        forever begin
            @(negedge clk);
            rst = reset;
            arf = m_if.arvalid && m_if.arready;
            rf  = m_if.rvalid && m_if.rready;
            av  = m_if.arvalid;
            @(posedge clk);
            #1;
            if (rst) begin
                active = 0; idx = 0; ar_wait = 0;
                m_if.arready = 1'b0;
                m_if.rvalid  = 1'b0;
            end else begin
                if (arf) begin
                    active = 1; idx = 0; ar_wait = 0;
                    ar_count++;
                end else if (av && !active) begin
                    ar_wait++;
                end
                if (rf) begin
                    if (m_if.rlast) active = 0;
                    idx++;
                    beats_seen++;
                end
                m_if.arready = !active && (ar_wait >= cfg_ar_delay);
                if (!active) begin
                    m_if.rvalid = 1'b0;
                end else if (!(m_if.rvalid && !rf)) begin
                    m_if.rvalid = cfg_rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                    m_if.rdata  = (idx == cfg_bad_data) ? 32'hDEAD_BEEF : pat_tab[idx % 8];
                    m_if.rresp  = (cfg_all_bad || idx == cfg_bad_resp) ? 2'b10 : 2'b00;
                    m_if.rlast  = (idx == cfg_last);
                end
            end
        end
    end

    initial begin : monitor
        bit prev_av, prev_fire;
        prev_av = 0; prev_fire = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_av = 0;
                prev_fire = 0;
            end else begin
                if (prev_av && !prev_fire && !m_if.arvalid) ar_drops++;
                prev_av   = m_if.arvalid;
                prev_fire = m_if.arvalid && m_if.arready;
            end
            if (done) done_total++;
        end
    end

    task automatic pulse_trigger();
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cyc, ar0, d0, drop0;
        set_cfg(v);
        ar0 = ar_count; d0 = done_total; drop0 = ar_drops;
        pulse_trigger();
        wait_done(cyc);
        check($sformatf("v%0d_done_seen", i), 32'(done), 32'd1);
        if (v.exp_cyc > 0) check($sformatf("v%0d_latency", i), cyc, v.exp_cyc);
        check($sformatf("v%0d_pass", i), 32'(pass), 32'(v.exp_pass));
        check($sformatf("v%0d_err_count", i), 32'(err_count), v.exp_err);
        check($sformatf("v%0d_proto_err", i), 32'(proto_err), 32'(v.exp_proto));
        check($sformatf("v%0d_first_bad", i), first_bad, v.exp_fb);
        check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        check($sformatf("v%0d_pass_hold", i), 32'(pass), 32'(v.exp_pass));
        check($sformatf("v%0d_done_once", i), done_total - d0, 32'd1);
        check($sformatf("v%0d_ar_once", i), ar_count - ar0, 32'd1);
        check($sformatf("v%0d_arvalid_stable", i), ar_drops - drop0, 32'd0);
    endtask

    initial begin : main
        int cyc, gap, ar0, b0, waitc;
        vec_t clean;

        pat_tab[0] = 32'h1234_5678; pat_tab[1] = 32'h8123_4567;
        pat_tab[2] = 32'h7812_3456; pat_tab[3] = 32'h6781_2345;
        pat_tab[4] = 32'h5678_1234; pat_tab[5] = 32'h4567_8123;
        pat_tab[6] = 32'h3456_7812; pat_tab[7] = 32'h2345_6781;

        //            ar  rnd bad_d bad_r all last cyc pass err proto first_bad
        vecs[0] = '{0,  0,  -1,   -1,   0,  15,  19,  1,  0,  0,   32'h0000_0000};
        vecs[1] = '{0,  0,   5,    9,   0,  15,  19,  0,  2,  0,   32'hDEAD_BEEF};
        vecs[2] = '{7,  1,  -1,   -1,   0,  15,  -1,  1,  0,  0,   32'h0000_0000};
        vecs[3] = '{0,  0,  -1,   -1,   0,  11,  15,  0,  0,  1,   32'h0000_0000};
        vecs[4] = '{0,  0,  -1,   -1,   0,  17,  21,  0,  0,  1,   32'h0000_0000};
        vecs[5] = '{0,  0,  -1,   -1,   1,  19,  23,  0,  16, 1,   32'h1234_5678};
        clean = vecs[0];

        reset = 1'b1;
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 32'(m_if.arvalid), 32'd0);
        check("rst_rready", 32'(m_if.rready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_first_bad", first_bad, 32'd0);
        check("const_arlen", 32'(m_if.arlen), 32'd15);
        check("const_arsize", 32'(m_if.arsize), 32'd2);
        check("const_arburst", 32'(m_if.arburst), 32'd1);
        check("const_awvalid", 32'(m_if.awvalid), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Trigger pulsed, then raised mid-burst and held: the burst must issue a
        // single AR, and the held trigger restarts after REPORT->IDLE, so arvalid
        // is first seen three samples after the done sample.
        set_cfg(clean);
        ar0 = ar_count;
        pulse_trigger();
        repeat (8) @(posedge clk);
        #1 trigger = 1'b1;
        wait_done(cyc);
        check("hold_done_seen", 32'(done), 32'd1);
        check("hold_ar_once", ar_count - ar0, 32'd1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!m_if.arvalid && gap < 10);
        check("hold_restart_gap", gap, 32'd3);
        @(posedge clk); #1 trigger = 1'b0;
        wait_done(cyc);
        check("hold_second_done", 32'(done), 32'd1);
        check("hold_second_pass", 32'(pass), 32'd1);
        check("hold_second_ar", ar_count - ar0, 32'd2);
        @(negedge clk);

        // Reset in the middle of a burst with one bad beat already counted.
        set_cfg(clean);
        cfg_bad_data = 2;
        b0 = beats_seen;
        pulse_trigger();
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while ((beats_seen - b0) < 6 && waitc < 100);
        check("midrst_reached_beat6", beats_seen - b0, 32'd6);
        check("midrst_err_before", 32'(err_count), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_arvalid", 32'(m_if.arvalid), 32'd0);
        check("midrst_rready", 32'(m_if.rready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_first_bad", first_bad, 32'd0);
        repeat (2) @(posedge clk);
        run_vec(6, clean);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
